// File: rtl/branch_flag_unit.sv
// Execute-stage NZCV flag register and branch resolver for B.cond, CBZ, CBNZ and B.
// The decision is registered and presented for one cycle alongside br_done.
module branch_flag_unit #(
  parameter bit          FWD   = 1'b1,
  parameter int unsigned WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       negative,
  input  logic       zero,
  input  logic       overflow,
  input  logic       carry_out,
  input  logic       set_flags,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic [3:0] cond,
  output logic       take_branch,
  output logic       br_done,
  output logic [3:0] flags_q
);

  if (WIDTH == 0) begin : g_width_chk
    $error("branch_flag_unit: WIDTH must be nonzero");
  end

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESOLVE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_ALWAYS = 2'b11
  } br_kind_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_HS = 4'h2, CC_LO = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  state_e     state_q, state_d;
  logic       take_q, take_d;
  logic [3:0] flags_d;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_true;
  logic       decision;

  assign alu_flags = {negative, zero, carry_out, overflow};

  // Forwarding lets a branch in the same cycle as a flag-setting op see the new flags.
  always_comb begin
    eff_flags = flags_q;
    if (FWD && set_flags) begin
      eff_flags = alu_flags;
    end
    {f_n, f_z, f_c, f_v} = eff_flags;
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      CC_EQ:   cond_true = f_z;
      CC_NE:   cond_true = !f_z;
      CC_HS:   cond_true = f_c;
      CC_LO:   cond_true = !f_c;
      CC_MI:   cond_true = f_n;
      CC_PL:   cond_true = !f_n;
      CC_VS:   cond_true = f_v;
      CC_VC:   cond_true = !f_v;
      CC_HI:   cond_true = f_c && !f_z;
      CC_LS:   cond_true = !(f_c && !f_z);
      CC_GE:   cond_true = (f_n == f_v);
      CC_LT:   cond_true = (f_n != f_v);
      CC_GT:   cond_true = !f_z && (f_n == f_v);
      CC_LE:   cond_true = !(!f_z && (f_n == f_v));
      CC_AL:   cond_true = 1'b1;
      CC_NV:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // CBZ/CBNZ test the live ALU zero (pass-B result), never the stored flags.
  always_comb begin
    decision = 1'b0;
    case (br_kind_e'(br_type))
      BR_COND:   decision = cond_true;
      BR_CBZ:    decision = zero;
      BR_CBNZ:   decision = !zero;
      BR_ALWAYS: decision = 1'b1;
      default:   decision = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (set_flags) begin
      flags_d = alu_flags;
    end
  end

  always_comb begin
    state_d = state_q;
    take_d  = 1'b0;
    case (state_q)
      ST_IDLE:    state_d = br_valid ? ST_RESOLVE : ST_IDLE;
      ST_RESOLVE: state_d = br_valid ? ST_RESOLVE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (br_valid) begin
      take_d = decision;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      take_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      take_q  <= take_d;
      flags_q <= flags_d;
    end
  end

  assign take_branch = take_q;
  assign br_done     = (state_q == ST_RESOLVE);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: one FWD=1 and one FWD=0 instance share stimulus;
// a reference model predicts decisions and a monitor checks them as br_done appears.
module tb_branch_flag_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       negative, zero, overflow, carry_out;
  logic       set_flags, br_valid;
  logic [1:0] br_type;
  logic [3:0] cond;

  logic       take1, done1, take0, done0;
  logic [3:0] flags1, flags0;

  always #5 clk = ~clk;

  branch_flag_unit #(.FWD(1'b1), .WIDTH(64)) u_fwd1 (
    .clk(clk), .reset_n(reset_n),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .set_flags(set_flags), .br_valid(br_valid), .br_type(br_type), .cond(cond),
    .take_branch(take1), .br_done(done1), .flags_q(flags1)
  );

  branch_flag_unit #(.FWD(1'b0), .WIDTH(64)) u_fwd0 (
    .clk(clk), .reset_n(reset_n),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .set_flags(set_flags), .br_valid(br_valid), .br_type(br_type), .cond(cond),
    .take_branch(take0), .br_done(done0), .flags_q(flags0)
  );

  typedef struct {
    logic        take0;
    logic        take1;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  mflags = 4'h0;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  logic        edone, e0, e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Condition truth: even codes test a base predicate, odd codes its inverse, code 7x is always.
  function automatic logic cond_holds(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cd[3:1] != 3'd7 && cd[0]) return !base;
    return base;
  endfunction

  function automatic logic ref_take(input logic [1:0] bt, input logic [3:0] cd,
                                    input logic [3:0] f, input logic z_live);
    case (bt)
      2'd1:    return z_live;
      2'd2:    return !z_live;
      2'd3:    return 1'b1;
      default: return cond_holds(cd, f);
    endcase
  endfunction

  task automatic drive(input logic sf, input logic [3:0] alu, input logic bv,
                       input logic [1:0] bt, input logic [3:0] cd);
    exp_t e;
    @(negedge clk);
    set_flags = sf;
    {negative, zero, carry_out, overflow} = alu;
    br_valid = bv;
    br_type  = bt;
    cond     = cd;
    if (bv) begin
      e.take1 = ref_take(bt, cd, sf ? alu : mflags, alu[2]);
      e.take0 = ref_take(bt, cd, mflags, alu[2]);
      e.cyc   = cyc;
      sb.push_back(e);
    end
    if (sf) mflags = alu;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
  endtask

  always @(posedge clk) begin
    #1;
    edone = 1'b0; e0 = 1'b0; e1 = 1'b0;
    while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
      n_vec++; n_miss++;
      $display("FAIL latency: decision from cycle %0d not presented by cycle %0d, required 1 cycle",
               sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
      edone = 1'b1;
      e0 = sb[0].take0;
      e1 = sb[0].take1;
      void'(sb.pop_front());
    end
    chk1("br_done_fwd1", done1, edone);
    chk1("br_done_fwd0", done0, edone);
    chk1("take_fwd1", take1, e1);
    chk1("take_fwd0", take0, e0);
    chk4("flags_fwd1", flags1, mflags);
    chk4("flags_fwd0", flags0, mflags);
  end

  task automatic reset_mid();
    drive(1'b1, 4'hF, 1'b0, 2'd0, 4'h0);
    drive(1'b0, 4'h0, 1'b1, 2'd3, 4'h0);
    @(negedge clk);
    set_flags = 1'b0;
    br_valid  = 1'b1;
    br_type   = 2'd3;
    #2;
    reset_n = 1'b0;
    sb.delete();
    mflags = 4'h0;
    #1;
    chk1("rst_take_fwd1", take1, 1'b0);
    chk1("rst_take_fwd0", take0, 1'b0);
    chk1("rst_done_fwd1", done1, 1'b0);
    chk1("rst_done_fwd0", done0, 1'b0);
    chk4("rst_flags_fwd1", flags1, 4'h0);
    chk4("rst_flags_fwd0", flags0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #2;
    chk1("post_rst_done_fwd1", done1, 1'b0);
    chk1("post_rst_done_fwd0", done0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    {negative, zero, overflow, carry_out} = 4'h0;
    set_flags = 1'b0; br_valid = 1'b0; br_type = 2'd0; cond = 4'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    reset_mid();
    idle(2);

    // Subtract overflow: NZCV = 0011, then VS and VC
    drive(1'b1, 4'b0011, 1'b0, 2'd0, 4'h0);
    drive(1'b0, 4'b0000, 1'b1, 2'd0, 4'b0110);
    drive(1'b0, 4'b0000, 1'b1, 2'd0, 4'b0111);

    // Add overflow with same-cycle branch: GE, LT from 0000 and LT from 1000
    drive(1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 4'b1001, 1'b1, 2'd0, 4'b1010);
    drive(1'b1, 4'b0000, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 4'b1001, 1'b1, 2'd0, 4'b1011);
    drive(1'b1, 4'b1000, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 4'b1001, 1'b1, 2'd0, 4'b1011);
    idle(1);

    // CBZ / CBNZ use live zero only; stored flags untouched
    drive(1'b0, 4'b0100, 1'b1, 2'd1, 4'h0);
    drive(1'b0, 4'b1011, 1'b1, 2'd1, 4'h0);
    drive(1'b0, 4'b1011, 1'b1, 2'd2, 4'h0);
    drive(1'b0, 4'b0100, 1'b1, 2'd2, 4'h0);
    idle(1);

    // Back-to-back EQ, NE, AL with Z=1
    drive(1'b1, 4'b0100, 1'b0, 2'd0, 4'h0);
    drive(1'b0, 4'h0, 1'b1, 2'd0, 4'h0);
    drive(1'b0, 4'h0, 1'b1, 2'd0, 4'h1);
    drive(1'b0, 4'h0, 1'b1, 2'd0, 4'hE);
    idle(2);

    // Full sweep: every NZCV value against every condition code
    for (int unsigned f = 0; f < 16; f++) begin
      drive(1'b1, 4'(f), 1'b0, 2'd0, 4'h0);
      for (int unsigned c = 0; c < 16; c++) begin
        drive(1'b0, 4'($urandom), 1'b1, 2'd0, 4'(c));
      end
    end
    idle(2);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom));
    end
    idle(3);

    chk1("scoreboard_drained", (sb.size() != 0), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Sits directly downstream of the 64-bit ALU in the execute stage.
- Holds the architectural NZCV flag register, loaded from the ALU flag outputs when an instruction sets flags.
- Evaluates B.cond, CBZ, CBNZ and B branch decisions, and delivers a registered take/not-take result to the fetch/PC logic one cycle later.
- Optionally forwards same-cycle flag updates so a flag-setting op and the following branch need no stall.

Parameters:
- FWD, 1, 1 = a branch presented in the same cycle as a set_flags op uses the incoming ALU flags; 0 = it uses the stored flags_q.
- WIDTH, 64, data width of alu_result (informational; the zero flag is taken from the ALU).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- negative  input  1  ALU N flag
- zero  input  1  ALU Z flag
- overflow  input  1  ALU V flag
- carry_out  input  1  ALU C flag
- set_flags  input  1  load ALU flags into NZCV this cycle
- br_valid  input  1  branch request present this cycle
- br_type  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
- cond  input  4  ARM condition code, used only when br_type=00
- take_branch  output  1  registered branch decision
- br_done  output  1  one-cycle pulse: take_branch is valid
- flags_q  output  4  stored {N,Z,C,V}

Behaviour:
- Reset (reset_n=0, asynchronous): flags_q=4'b0000, take_branch=0, br_done=0, evaluation state=IDLE. Reset asserted mid-operation discards any pending decision, and br_done stays 0 in the cycle after release.
- Flag register: on the rising edge with set_flags=1, flags_q <= {negative, zero, carry_out, overflow}. Otherwise flags_q holds.
- Effective flags for evaluation:
  - FWD=1 and set_flags=1: the live ALU flags.
  - Otherwise: flags_q.
- State machine (IDLE, RESOLVE):
  - IDLE -> RESOLVE on br_valid=1; the decision is computed combinationally and registered.
  - RESOLVE: br_done=1 and take_branch holds the decision for exactly one cycle.
  - RESOLVE -> RESOLVE if br_valid=1 again (back-to-back branches give continuous br_done).
  - RESOLVE -> IDLE otherwise.
  - In IDLE, br_done=0 and take_branch=0.
- Latency: decision visible exactly 1 cycle after the br_valid edge.
- CBZ/CBNZ: the ALU is driven with cntrol=000 (pass B), so the live ALU zero input is used. CBZ takes the branch when zero=1; CBNZ takes it when zero=0. These never consult flags_q and are unaffected by FWD.
- B (br_type=11): always taken.
- B.cond codes:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !(C&!Z)
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V))
  - 1110/1111 always.
- Simultaneous set_flags and br_valid:
  - flags_q updates on that edge.
  - The branch decision uses the new flags if FWD=1, the old flags if FWD=0.
- X/unused inputs: cond is ignored unless br_type=00. Flag inputs are ignored unless set_flags=1 or br_type is CBZ/CBNZ.

Test Plan:
- Reset mid-run: br_valid=1, br_type=11, then assert reset_n=0 before the next edge -> take_branch=0, br_done=0, flags_q=0000 immediately, and after release.
- Subtract-overflow flags: set_flags=1 with ALU flags from A=64'h8000000000000000 minus B=12353 (N=0, Z=0, C=1, V=1) -> flags_q=4'b0011. The next cycle's B.cond VS (0110) gives take_branch=1; VC (0111) gives 0.
- Add overflow: A=B=64'h7FFFFFFFFFFFFFFF (N=1, V=1, C=0, Z=0) with set_flags=1 and br_valid=1, cond GE (1010) in the same cycle -> FWD=1 gives take_branch=1 (N==V). Rerun with FWD=0 and prior flags_q=0000 -> GE also gives 1 (0==0); LT then differs: FWD=1 gives 0, FWD=0 gives 0. Add a case with prior flags_q=1000 where LT gives FWD=1 ->0, FWD=0 ->1.
- CBZ/CBNZ: ALU cntrol=000 with B=0 (zero=1), br_type=01 -> take_branch=1. With B=64'h5, br_type=01 -> 0 and br_type=10 -> 1. flags_q is unchanged throughout.
- Back-to-back branches: br_valid=1 for 3 cycles with cond EQ, NE, AL and flags_q Z=1 -> br_done=1,1,1 and take_branch=1,0,1. br_done drops to 0 in the cycle after br_valid deasserts.
- Full cond sweep: load each of the 16 NZCV values, check all 16 cond codes against the table above -> 256 checks, all matching.
